// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared constants, state codes and opcode decode for cpu_sequencer
package cpu_seq_pkg;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  typedef struct packed {
    logic jump;
    logic store;
    logic wr;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d.jump  = op[3];
    d.store = ~op[3] & op[1] & ~op[0];
    d.wr    = ~op[3] & ~d.store;
    return d;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction fetch and data store handshake bundle
interface cpu_sequencer_if;

  logic       imem_req;
  logic       imem_ack;
  logic [7:0] inst_in;
  logic       dmem_wr_req;
  logic       dmem_ack;

  modport master (
    output imem_req,
    output dmem_wr_req,
    input  imem_ack,
    input  inst_in,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_wr_req,
    output imem_ack,
    output inst_in,
    output dmem_ack
  );

endinterface

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - loadable wait counter flagging the last allowed unacknowledged cycle
module seq_wait_timer #(
  parameter  int TIMEOUT_CYCLES = 15,
  localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // expired is qualified by en so an ack in the final cycle wins
  assign expired = en && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer with store handshake and bus timeout
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  cpu_sequencer_if.master       bus,
  output logic [7:0]            ir_out,
  output logic                  reg_write,
  output logic                  pc_inc,
  output logic                  pc_jump,
  output logic                  busy,
  output logic                  fault,
  output logic [CNT_W-1:0]      instr_count
);

  logic [2:0]       state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_active;
  logic             acked;
  logic             expired;
  logic             retire;
  dec_t             dec;

  assign dec        = decode_op(ir_q[OPC_HI:OPC_LO]);
  assign req_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign acked      = ((state_q == ST_FETCH) && bus.imem_ack) ||
                      ((state_q == ST_MEM)   && bus.dmem_ack);

  seq_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (!req_active || acked),
    .en       (req_active && !acked),
    .load     (1'b0),
    .load_val ('0),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (acked) begin
          ir_d    = bus.inst_in;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec.store) state_d = ST_MEM;
        else           retire  = 1'b1;
      end
      ST_MEM: begin
        if (acked)        retire  = 1'b1;
        else if (expired) state_d = ST_FAULT;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    // run is only consulted at an instruction boundary
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.dmem_wr_req = (state_q == ST_MEM);
  assign pc_jump         = (state_q == ST_EXEC) &&  dec.jump;
  assign pc_inc          = (state_q == ST_EXEC) && !dec.jump;
  assign reg_write       = (state_q == ST_EXEC) &&  dec.wr;
  assign busy            = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                           (state_q == ST_EXEC)  || (state_q == ST_MEM);
  assign fault           = (state_q == ST_FAULT);
  assign ir_out          = ir_q;
  assign instr_count     = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed plus randomized checks of cpu_sequencer against an opcode-rule model
module tb_cpu_sequencer;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] ir_out;
  logic       reg_write, pc_inc, pc_jump, busy, fault;
  logic [7:0] instr_count;

  int         n_assert = 0;
  int         n_fail = 0;
  int         exp_count = 0;
  logic [7:0] last_ir = 8'h00;

  cpu_sequencer_if bus ();

  cpu_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bus         (bus),
    .ir_out      (ir_out),
    .reg_write   (reg_write),
    .pc_inc      (pc_inc),
    .pc_jump     (pc_jump),
    .busy        (busy),
    .fault       (fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {jump, store, wr} from the opcode rules: high half jumps, ops 2 and 6 store, the rest write
  function automatic logic [2:0] ref_ctl(input logic [7:0] inst);
    int op;
    bit j, s, w;
    op = int'(inst) / 16;
    j  = (op >= 8);
    s  = (op < 8) && (op % 4 == 2);
    w  = (op < 8) && !s;
    return {j, s, w};
  endfunction

  // Entered at a falling edge with the DUT in its first FETCH cycle
  task automatic run_instr(input logic [7:0] inst, input int wi, input int wd, input logic run_after);
    logic [2:0] c;
    c = ref_ctl(inst);
    for (int i = 0; i < wi; i++) begin
      chk("fetch_wait_req", bus.imem_req, 1);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'($urandom);
      bus.inst_in  = 8'($urandom);
      @(negedge clk);
    end
    chk("fetch_req", bus.imem_req, 1);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.inst_in  = inst;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.inst_in  = 8'($urandom);
    chk("decode_ir", ir_out, inst);
    chk("decode_req", bus.imem_req, 0);
    chk("decode_strobes", {reg_write, pc_inc, pc_jump}, 0);
    chk("decode_busy", busy, 1);
    run = run_after;
    @(negedge clk);
    chk("exec_pc_jump", pc_jump, c[2]);
    chk("exec_pc_inc", pc_inc, !c[2]);
    chk("exec_reg_write", reg_write, c[0]);
    chk("exec_dmem_req", bus.dmem_wr_req, 0);
    @(negedge clk);
    if (c[1]) begin
      for (int i = 0; i < wd; i++) begin
        chk("mem_wait_req", bus.dmem_wr_req, 1);
        chk("mem_wait_strobes", {reg_write, pc_inc, pc_jump}, 0);
        @(negedge clk);
      end
      chk("mem_req", bus.dmem_wr_req, 1);
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
    end
    exp_count = (exp_count + 1) % 256;
    last_ir   = inst;
    chk("retire_count", instr_count, exp_count);
    chk("next_req", bus.imem_req, run_after);
    chk("next_busy", busy, run_after);
    chk("next_dmem_req", bus.dmem_wr_req, 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_fault", fault, 0);
    exp_count = 0;
    last_ir   = 8'h00;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    chk("rst_release_req", bus.imem_req, 1);
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.inst_in  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.imem_req, bus.dmem_wr_req, reg_write, pc_inc, pc_jump, busy, fault}, 0);
    chk("reset_ir", ir_out, 0);
    chk("reset_count", instr_count, 0);

    reset = 1'b1;
    @(negedge clk);
    chk("idle_run0", busy, 0);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    chk("idle_spurious_ack", {bus.imem_req, busy, ir_out}, 0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("start_req", bus.imem_req, 1);

    run_instr(8'h05, 0, 0, 1'b1);
    run_instr(8'h83, 0, 0, 1'b1);
    run_instr(8'h2A, 0, 3, 1'b1);
    for (int k = 0; k < 20; k++)
      run_instr(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1);

    @(negedge clk);
    chk("midfetch_req", bus.imem_req, 1);
    pulse_reset();

    run_instr(8'h11, TMO - 1, 0, 1'b1);
    run_instr(8'h46, 0, TMO - 1, 1'b1);

    run_instr(8'h05, 0, 0, 1'b0);
    @(negedge clk);
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_req", bus.imem_req, 0);
    run = 1'b1;
    @(negedge clk);
    chk("restart_req", bus.imem_req, 1);

    for (int i = 0; i < TMO; i++) begin
      chk("timeout_wait_req", bus.imem_req, 1);
      chk("timeout_wait_fault", fault, 0);
      @(negedge clk);
    end
    chk("fault_set", fault, 1);
    chk("fault_req", bus.imem_req, 0);
    chk("fault_busy", busy, 0);
    chk("fault_ir_hold", ir_out, last_ir);
    chk("fault_count_hold", instr_count, exp_count);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("fault_sticky_outs", {bus.imem_req, bus.dmem_wr_req, reg_write, pc_inc, pc_jump, busy}, 0);
    chk("fault_sticky_count", instr_count, exp_count);
    pulse_reset();

    for (int k = 0; k < 256; k++)
      run_instr(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
    chk("count_wrap", instr_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
